seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle radix-2 restoring divider; the responder to the ALU's divide request in the execute stage.
- ALU drives operands, signedness, start and annul; divider returns {remainder, quotient} with a ready flag.
- ALU holds the pipeline stalled while start is high and ready is low.
- HI receives the remainder (result_o upper half); LO receives the quotient (lower half).

Parameters:
- WIDTH, 32, operand width in bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- signed_div_i  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU)
- opdata1_i  input  WIDTH  dividend
- opdata2_i  input  WIDTH  divisor
- start_i  input  1  divide request; level, held by requester until ready_o seen
- annul_i  input  1  abort in-flight divide (exception/flush)
- result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
- ready_o  output  1  result_o valid

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, result_o=0, ready_o=0, counter=0, internal dividend/divisor/partial-remainder registers=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - ready_o=0.
  - On an edge with start_i=1 and annul_i=0 (edge E0), capture the operands and signed_div_i. Operands need not be held afterwards.
  - If divisor==0 at E0, go to DIVZERO. Otherwise go to ON with counter=0.
- Signed capture:
  - Negative operands are converted to two's-complement magnitude.
  - Record quotient sign = dividend sign XOR divisor sign.
  - Record remainder sign = dividend sign.
- ON:
  - One restoring step per edge: shift the partial remainder left, bringing in the next dividend MSB.
  - Trial-subtract the divisor magnitude (WIDTH+1-bit subtract). If non-negative, keep the difference and set the quotient bit to 1; else restore and set the bit to 0.
  - The counter increments each edge.
  - After WIDTH steps (edges E1..E32 for WIDTH=32), go to END.
  - annul_i=1 on any ON edge: go to IDLE, ready_o stays 0, result_o unchanged.
  - start_i dropping during ON is ignored; only annul_i aborts.
- DIVZERO:
  - Next edge goes to END with result_o = 0 for both halves.
  - MIPS leaves HI/LO unpredictable; we define them as 0.
- END entry edge:
  - Apply sign fix-up: negate the quotient if the quotient sign is set, negate the remainder if the remainder sign is set.
  - Register result_o and set ready_o=1.
- Latency:
  - Normal divide: ready_o first high after edge E33 (WIDTH+1 edges after the start-sampling edge).
  - Divide-by-zero: ready_o first high after edge E2.
- END:
  - While start_i=1, stay in END, keep ready_o=1, hold result_o. There is no re-trigger.
  - When start_i=0, the next edge goes to IDLE and clears ready_o.
  - result_o holds its value until the next accepted start.
  - The ALU drops start_i combinationally on ready_o, so ready_o is normally high for exactly one cycle.
- annul_i in IDLE or END:
  - IDLE: blocks acceptance of start_i.
  - END: forces IDLE and clears ready_o on that edge.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (two's-complement wrap). No trap.
- Unsigned mode: no sign conversion and no fix-up; full 32-bit magnitude.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. The divide is lost and the requester must reissue.

Test Plan:
- Unsigned 100/7, start held until ready -> ready_o high after E33, result_o={32'd2, 32'd14}; ready_o low one cycle after start_i drops.
- Signed -7/2 (0xFFFFFFF9, 0x2) -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide-by-zero, 0x1234/0, signed and unsigned -> ready_o after E2, result_o=0.
- Signed 0x80000000/0xFFFFFFFF -> {0, 0x80000000}. Unsigned 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
- annul_i pulsed at E10, then a new start 5/5 -> no ready_o for the aborted divide; new result {0, 1} after a further 33 edges.
- rst pulsed low at E20 -> ready_o=0 and result_o=0 immediately, state IDLE. Hold start_i high across END for 3 cycles -> ready_o stays 1 and result_o is stable, with no restart.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider serving the ALU's DIV/DIVU requests.
// Returns {remainder, quotient} with a registered ready flag.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIVZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, dvs, rem, quo;
  logic             q_neg, r_neg;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff, mag1, mag2;
  logic             ge, go, neg1, neg2;

  // Trial subtract: only the low WIDTH bits of the difference matter when it
  // is kept, because the partial remainder always stays below the divisor.
  always_comb begin
    rem_sh = {rem, dvd[WIDTH-1]};
    ge     = rem_sh >= {1'b0, dvs};
    diff   = rem_sh[WIDTH-1:0] - dvs;
    neg1   = signed_div_i & opdata1_i[WIDTH-1];
    neg2   = signed_div_i & opdata2_i[WIDTH-1];
    mag1   = neg1 ? -opdata1_i : opdata1_i;
    mag2   = neg2 ? -opdata2_i : opdata2_i;
    go     = start_i & ~annul_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_o <= 1'b0;
          if (go) begin
            dvd   <= mag1;
            dvs   <= mag2;
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
            q_neg <= neg1 ^ neg2;
            r_neg <= neg1;
            state <= (opdata2_i == '0) ? S_DIVZERO : S_ON;
          end
        end
        // Divide-by-zero answers on the second edge, defined as all zeros.
        S_DIVZERO: begin
          if (annul_i) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            cnt <= CW'(1);
          end else begin
            result_o <= '0;
            ready_o  <= 1'b1;
            state    <= S_END;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state <= S_IDLE;
          end else if (cnt == LAST) begin
            result_o <= {(r_neg ? -rem : rem), (q_neg ? -quo : quo)};
            ready_o  <= 1'b1;
            state    <= S_END;
          end else begin
            dvd <= dvd << 1;
            cnt <= cnt + CW'(1);
            rem <= ge ? diff : rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ge};
          end
        end
        S_END: begin
          if (annul_i || !start_i) begin
            state   <= S_IDLE;
            ready_o <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized bench for seq_divider against a plain-arithmetic divide model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = '0, op2 = '0;
  logic        start = 1'b0, annul = 1'b0;
  logic [63:0] result;
  logic        ready;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_exp = '0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div),
    .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
    .result_o(result), .ready_o(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: language-level division; truncation to 32 bits gives the wrap case.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called just after a rising edge; E0 is the first edge that follows.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [63:0] exp;
    int n;
    exp = ref_div(sgn, a, b);
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom);
      end
    end while (!ready && n < 45);
    chk("latency", 64'(n), (b == 0) ? 64'd3 : 64'd34);
    chk("result", result, exp);
    if (hold) begin
      repeat (3) begin
        @(posedge clk); #1;
        chk("hold_ready", 64'(ready), 64'd1);
        chk("hold_result", result, exp);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("ready_clear", 64'(ready), 64'd0);
    chk("result_keep", result, exp);
    last_exp = exp;
  endtask

  initial begin
    bit seen;
    logic [31:0] a, b;
    bit s;

    #12;
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    run_div(1'b0, 32'd100, 32'd7, 1'b0);
    run_div(1'b1, 32'hFFFFFFF9, 32'h2, 1'b0);
    run_div(1'b1, 32'h7, 32'hFFFFFFFE, 1'b0);
    run_div(1'b1, 32'h1234, 32'h0, 1'b0);
    run_div(1'b0, 32'h1234, 32'h0, 1'b0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_div(1'b0, 32'hFFFFFFFF, 32'h1, 1'b0);
    run_div(1'b0, 32'hFFFFFFFF, 32'h80000000, 1'b1);

    // Annul on the tenth step edge: nothing comes back, result untouched.
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ready) seen = 1'b1; end
    chk("annul_no_ready", 64'(seen), 64'd0);
    chk("annul_result", result, last_exp);
    run_div(1'b0, 32'd5, 32'd5, 1'b0);

    // Annul held in IDLE blocks acceptance.
    start = 1'b1; annul = 1'b1; op1 = 32'd9; op2 = 32'd3;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0; annul = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ready) seen = 1'b1; end
    chk("idle_annul_block", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of a divide.
    signed_div = 1'b1; op1 = 32'hDEADBEEF; op2 = 32'd77; start = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_result", result, 64'd0);
    start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("postrst_ready", 64'(ready), 64'd0);
    last_exp = 64'd0;

    run_div(1'b1, 32'hFFFFFF00, 32'd7, 1'b1);

    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(1, 15));
        1: b = 32'($urandom_range(0, 2)) - 32'd1;
        default: b = $urandom;
      endcase
      run_div(s, a, b, (i % 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
